joystick_debounce: RTL and testbench

JOYSTICK_DEBOUNCE -- requirements
Module: joystick_debounce

---
 rtl/joystick_debounce.sv | 158 +++++++++++++++
 tb/tb_joystick_debounce.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : joystick_debounce
//  Description : Five-channel joystick contact debouncer. Each raw active-low
//                contact is synchronised, then debounced by a saturating
//                disagreement counter. Produces debounced levels, one-cycle
//                press pulses and a priority-encoded held-key code.
//  Revision    : 1.0  initial release
// ============================================================================
module joystick_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_z,
    output logic       db_up,
    output logic       db_down,
    output logic       db_left,
    output logic       db_right,
    output logic       db_z,
    output logic [4:0] press,
    output logic [2:0] key_code,
    output logic       key_valid
);

    localparam int NUM_KEYS = 5;
    localparam int CNT_W    = 20;

    // Counter reaches this value on the last disagreeing cycle before the flip
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Channel bit positions inside the packed key vectors
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_Z     = 4;

    // Held-key code values
    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_Z     = 3'd1;
    localparam logic [2:0] CODE_UP    = 3'd2;
    localparam logic [2:0] CODE_DOWN  = 3'd3;
    localparam logic [2:0] CODE_LEFT  = 3'd4;
    localparam logic [2:0] CODE_RIGHT = 3'd5;

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] sync_meta_q;
    logic [NUM_KEYS-1:0] sync_q;
    logic [NUM_KEYS-1:0] db_all_q;
    logic [NUM_KEYS-1:0] db_all_d;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] press_d;
    logic [2:0]          key_code_q;
    logic [2:0]          key_code_d;
    logic                key_valid_q;
    logic                key_valid_d;

    assign raw_keys = {key_z, key_right, key_left, key_down, key_up};

    // Two-flop synchroniser; released (1) is the safe idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q <= '1;
            sync_q      <= '1;
        end else begin
            sync_meta_q <= raw_keys;
            sync_q      <= sync_meta_q;
        end
    end

    // One independent debounce channel per key
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             db_q;
        logic             db_d;

        // Count consecutive disagreeing cycles; flip the level on the last one
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (sync_q[k] == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LIMIT) begin
                db_d  = sync_q[k];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Channel state register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                db_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign db_all_q[k] = db_q;
        assign db_all_d[k] = db_d;
    end

    // A press is a debounced 1->0 transition happening at this edge
    always_comb begin
        press_d = db_all_q & ~db_all_d;
    end

    // Priority encode the currently debounced levels: z > up > down > left > right
    always_comb begin
        key_code_d = CODE_NONE;
        if (!db_all_q[KEY_Z]) begin
            key_code_d = CODE_Z;
        end else if (!db_all_q[KEY_UP]) begin
            key_code_d = CODE_UP;
        end else if (!db_all_q[KEY_DOWN]) begin
            key_code_d = CODE_DOWN;
        end else if (!db_all_q[KEY_LEFT]) begin
            key_code_d = CODE_LEFT;
        end else if (!db_all_q[KEY_RIGHT]) begin
            key_code_d = CODE_RIGHT;
        end
        key_valid_d = (key_code_d != CODE_NONE);
    end

    // Output registers for pulses and held-key code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q     <= '0;
            key_code_q  <= CODE_NONE;
            key_valid_q <= 1'b0;
        end else begin
            press_q     <= press_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign db_up     = db_all_q[KEY_UP];
    assign db_down   = db_all_q[KEY_DOWN];
    assign db_left   = db_all_q[KEY_LEFT];
    assign db_right  = db_all_q[KEY_RIGHT];
    assign db_z      = db_all_q[KEY_Z];
    assign press     = press_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_joystick_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joystick_debounce
//  Description : Self-checking bench for joystick_debounce (DEBOUNCE_CYCLES=4).
//                A history-window model predicts outputs every cycle; directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_joystick_debounce;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       key_up, key_down, key_left, key_right, key_z;
    logic       db_up, db_down, db_left, db_right, db_z;
    logic [4:0] press;
    logic [2:0] key_code;
    logic       key_valid;

    int checks = 0;
    int errors = 0;

    joystick_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_z     (key_z),
        .db_up     (db_up),
        .db_down   (db_down),
        .db_left   (db_left),
        .db_right  (db_right),
        .db_z      (db_z),
        .press     (press),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Held-key code from debounced levels (bit order {z,right,left,down,up})
    function automatic logic [2:0] prio(input bit [4:0] lvl);
        if (!lvl[4]) return 3'd1;
        if (!lvl[0]) return 3'd2;
        if (!lvl[1]) return 3'd3;
        if (!lvl[2]) return 3'd4;
        if (!lvl[3]) return 3'd5;
        return 3'd0;
    endfunction

    // Model state: raw samples and the synchronised values seen at each edge
    bit [4:0] raw_hist[$];
    bit [4:0] sync_hist[$];
    bit [4:0] db_m    = 5'b11111;
    bit [4:0] press_m = 5'b00000;
    bit [2:0] code_m  = 3'd0;

    // Model: a level flips when the last D synchronised samples all disagree with it
    always @(posedge clk) begin : p_model
        bit [4:0] raw_now;
        bit [4:0] sv;
        bit [4:0] db_new;
        bit       flip;
        if (reset) begin
            raw_hist.delete();
            sync_hist.delete();
            db_m    = 5'b11111;
            press_m = 5'b00000;
            code_m  = 3'd0;
        end else begin
            raw_now = {key_z, key_right, key_left, key_down, key_up};
            sv = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'b11111;
            raw_hist.push_back(raw_now);
            sync_hist.push_back(sv);
            db_new = db_m;
            for (int k = 0; k < 5; k++) begin
                if (sync_hist.size() >= D) begin
                    flip = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (sync_hist[sync_hist.size()-1-j][k] == db_m[k]) flip = 1'b0;
                    if (flip) db_new[k] = ~db_m[k];
                end
            end
            press_m = db_m & ~db_new;
            code_m  = prio(db_m);
            db_m    = db_new;
        end
        #1;
        chk("model_db", {27'd0, db_z, db_right, db_left, db_down, db_up}, {27'd0, db_m});
        chk("model_press", {27'd0, press}, {27'd0, press_m});
        chk("model_code", {29'd0, key_code}, {29'd0, code_m});
        chk("model_valid", {31'd0, key_valid}, {31'd0, (code_m != 3'd0)});
    end

    // Advance n rising edges, then settle away from the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : p_stim
        reset = 1'b1;
        {key_z, key_right, key_left, key_down, key_up} = 5'b11111;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_db", {27'd0, db_z, db_right, db_left, db_down, db_up}, 32'h1f);
        chk("reset_press", {27'd0, press}, 32'h0);
        chk("reset_code", {29'd0, key_code}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(4);

        // Single key_up press: falls on the 6th edge, pulse, code one edge later
        @(negedge clk); key_up = 1'b0;
        step(5);
        chk("up_edge5_db", {31'd0, db_up}, 32'd1);
        step(1);
        chk("up_edge6_db", {31'd0, db_up}, 32'd0);
        chk("up_edge6_press", {27'd0, press}, 32'b00001);
        step(1);
        chk("up_edge7_press", {27'd0, press}, 32'd0);
        chk("up_edge7_code", {29'd0, key_code}, 32'd2);
        chk("up_edge7_valid", {31'd0, key_valid}, 32'd1);
        @(negedge clk); key_up = 1'b1;
        step(6);
        chk("up_rel_db", {31'd0, db_up}, 32'd1);
        chk("up_rel_press", {27'd0, press}, 32'd0);
        step(1);
        chk("up_rel_code", {29'd0, key_code}, 32'd0);
        step(3);

        // Glitch one cycle short of the limit: no change
        @(negedge clk); key_up = 1'b0;
        repeat (3) @(negedge clk);
        key_up = 1'b1;
        step(8);
        chk("glitch3_db", {31'd0, db_up}, 32'd1);

        // key_left bouncing every 2 cycles for 20 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); key_left = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        key_left = 1'b1;
        step(8);
        chk("bounce_db_left", {31'd0, db_left}, 32'd1);
        chk("bounce_press", {27'd0, press}, 32'd0);
        chk("bounce_code", {29'd0, key_code}, 32'd0);

        // z and down together
        @(negedge clk); key_z = 1'b0; key_down = 1'b0;
        step(6);
        chk("zd_db_z", {31'd0, db_z}, 32'd0);
        chk("zd_db_down", {31'd0, db_down}, 32'd0);
        chk("zd_press", {27'd0, press}, 32'b10010);
        step(1);
        chk("zd_code", {29'd0, key_code}, 32'd1);
        chk("zd_press_gone", {27'd0, press}, 32'd0);

        // Release z, then down
        @(negedge clk); key_z = 1'b1;
        step(7);
        chk("z_rel_db", {31'd0, db_z}, 32'd1);
        step(1);
        chk("down_only_code", {29'd0, key_code}, 32'd3);
        @(negedge clk); key_down = 1'b1;
        step(6);
        chk("down_rel_db", {31'd0, db_down}, 32'd1);
        chk("down_rel_press", {27'd0, press}, 32'd0);
        step(1);
        chk("down_rel_code", {29'd0, key_code}, 32'd0);
        chk("down_rel_valid", {31'd0, key_valid}, 32'd0);
        step(3);

        // key_right held, reset mid-count
        @(negedge clk); key_right = 1'b0;
        step(3);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("midrst_db_right", {31'd0, db_right}, 32'd1);
        chk("midrst_press", {27'd0, press}, 32'd0);
        chk("midrst_valid", {31'd0, key_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(5);
        chk("right_edge5_db", {31'd0, db_right}, 32'd1);
        step(1);
        chk("right_edge6_db", {31'd0, db_right}, 32'd0);
        chk("right_press", {27'd0, press}, 32'b01000);
        step(1);
        chk("right_code", {29'd0, key_code}, 32'd5);

        // key_up over a held key_right
        @(negedge clk); key_up = 1'b0;
        step(6);
        chk("upright_db_up", {31'd0, db_up}, 32'd0);
        chk("upright_code_before", {29'd0, key_code}, 32'd5);
        step(1);
        chk("upright_code_after", {29'd0, key_code}, 32'd2);
        @(negedge clk); key_up = 1'b1;
        step(7);
        chk("upright_code_back", {29'd0, key_code}, 32'd5);
        chk("upright_valid", {31'd0, key_valid}, 32'd1);

        // Reset while a debounced key is held: one fresh pulse afterwards
        @(negedge clk); reset = 1'b1;
        #1;
        chk("heldrst_db_right", {31'd0, db_right}, 32'd1);
        chk("heldrst_code", {29'd0, key_code}, 32'd0);
        @(negedge clk); reset = 1'b0;
        step(6);
        chk("heldrst_db_after", {31'd0, db_right}, 32'd0);
        chk("heldrst_press", {27'd0, press}, 32'b01000);

        @(negedge clk); key_right = 1'b1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
